// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, stall and flush control for the 5-stage ARM pipeline.
// Shadows E/M/W destination bits and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Ra1D,
    input  logic [3:0]       Ra2D,
    input  logic [3:0]       WriteAddrD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount
);

    typedef struct packed {
        logic       valid;
        logic [3:0] wa;
        logic       rw;
        logic       m2r;
        logic       pcs;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           r_e;
    stage_t           r_m;
    stage_t           r_w;
    logic [3:0]       r_ra1e;
    logic [3:0]       r_ra2e;
    logic [CNT_W-1:0] r_cnt;

    stage_t     w_d;
    logic       w_ldr;
    logic       w_pcpend;
    logic       w_stallf;
    logic       w_flushe;
    logic       w_flushd;
    logic [1:0] w_fwda;
    logic [1:0] w_fwdb;
    logic       w_unused;

    // M beats W; R15 reads never forward since the PC path supplies them
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input stage_t     m,
        input stage_t     w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'd15) begin
            if (m.valid && m.rw && (m.wa == ra))
                sel = 2'b10;
            else if (w.valid && w.rw && (w.wa == ra))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_d = {1'b1, WriteAddrD, RegWriteD, MemtoRegD, PCSrcD};

    always_comb begin
        w_ldr = r_e.valid & r_e.m2r & r_e.rw
              & (r_e.wa != 4'd15)
              & ((r_e.wa == Ra1D) | (r_e.wa == Ra2D));
        w_pcpend = PCSrcD
                 | (r_e.valid & r_e.pcs)
                 | (r_m.valid & r_m.pcs);
        w_stallf = w_ldr | w_pcpend;
        w_flushe = w_ldr | BranchTakenE;
        w_flushd = w_pcpend | BranchTakenE;
        w_fwda   = fwd_sel(r_ra1e, r_m, r_w);
        w_fwdb   = fwd_sel(r_ra2e, r_m, r_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e    <= '0;
            r_m    <= '0;
            r_w    <= '0;
            r_ra1e <= '0;
            r_ra2e <= '0;
            r_cnt  <= '0;
        end else begin
            r_w <= r_m;
            r_m <= r_e;
            if (w_flushe) begin
                r_e    <= '0;
                r_ra1e <= '0;
                r_ra2e <= '0;
            end else begin
                r_e    <= w_d;
                r_ra1e <= Ra1D;
                r_ra2e <= Ra2D;
            end
            if (w_stallf && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Held in reset, the pipeline sees no stall or flush at all
    assign forwardAE  = reset ? w_fwda : 2'b00;
    assign forwardBE  = reset ? w_fwdb : 2'b00;
    assign StallF     = reset & w_stallf;
    assign StallD     = reset & w_ldr;
    assign FlushD     = reset & w_flushd;
    assign FlushE     = reset & w_flushe;
    assign StallCount = r_cnt;

    assign w_unused = ^{r_m.m2r, r_w.m2r, r_w.pcs};

endmodule
